// File: rtl/serial_paralelo_pkg.sv
// Shared types and helpers for the parametrised serial-to-parallel receiver.
package serial_paralelo_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LOCKING = 2'd1,
        ACTIVE  = 2'd2
    } sp_state_t;

    localparam logic [7:0] SP_DEFAULT_COM = 8'hBC;

    function automatic int unsigned sp_clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sp_shift_window.sv
// Sliding WIDTH-bit window over the serial stream with fill tracking and COM compare.
module sp_shift_window
    import serial_paralelo_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COM_SYMBOL = WIDTH'(SP_DEFAULT_COM)
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             fill_clr,
    input  logic             data_in,
    output logic [WIDTH-1:0] window,
    output logic             com_hit,
    output logic             fill_ok
);

    localparam int unsigned FW = sp_clog2(WIDTH);

    // The oldest window bit is never needed again, so only WIDTH-1 bits are stored.
    logic [WIDTH-2:0] shift_reg;
    logic [FW-1:0]    fill_cnt;

    assign window  = {shift_reg, data_in};
    assign com_hit = (window == COM_SYMBOL);
    assign fill_ok = (fill_cnt == FW'(WIDTH - 1));

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            shift_reg <= '0;
            fill_cnt  <= '0;
        end else begin
            shift_reg <= window[WIDTH-2:0];
            if (fill_clr)
                fill_cnt <= '0;
            else if (!fill_ok)
                fill_cnt <= fill_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/serial_paralelo_param.sv
// Serial-to-parallel receiver: COM hunt, lock after COM_COUNT aligned COMs, symbol delivery.
// Optional loss-of-lock after MAX_GAP non-COM symbols: define SP_LOSS_DETECT_EN.
module serial_paralelo_param
    import serial_paralelo_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COM_SYMBOL = WIDTH'(SP_DEFAULT_COM),
    parameter int               COM_COUNT  = 4,
    parameter int               MAX_GAP    = 64
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             active
);

    localparam int unsigned BW = sp_clog2(WIDTH);
    localparam int unsigned CW = sp_clog2(COM_COUNT + 1);

    if (WIDTH < 4 || COM_COUNT < 1 || MAX_GAP < 1 || COM_SYMBOL == '0) begin : g_param_check
        $error("serial_paralelo_param: invalid parameter set");
    end

    sp_state_t        state;
    logic [BW-1:0]    bit_cnt;
    logic [CW-1:0]    com_cnt;
    logic [WIDTH-1:0] window;
    logic             com_hit;
    logic             fill_ok;
    logic             fill_clr;
    logic             boundary;

    assign boundary = (bit_cnt == BW'(WIDTH - 1));

`ifdef SP_LOSS_DETECT_EN
    localparam int unsigned GW = sp_clog2(MAX_GAP + 1);
    logic [GW-1:0] gap_cnt;
    logic          gap_expire;

    assign gap_expire = (gap_cnt == GW'(MAX_GAP - 1));
    assign fill_clr   = (state == ACTIVE) && boundary && !com_hit && gap_expire;
`else
    assign fill_clr   = 1'b0;
`endif

    sp_shift_window #(
        .WIDTH      (WIDTH),
        .COM_SYMBOL (COM_SYMBOL)
    ) u_window (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .fill_clr (fill_clr),
        .data_in  (data_in),
        .window   (window),
        .com_hit  (com_hit),
        .fill_ok  (fill_ok)
    );

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state     <= HUNT;
            bit_cnt   <= '0;
            com_cnt   <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            active    <= 1'b0;
`ifdef SP_LOSS_DETECT_EN
            gap_cnt   <= '0;
`endif
        end else begin
            valid_out <= 1'b0;
            if (state != HUNT)
                bit_cnt <= boundary ? '0 : bit_cnt + 1'b1;

            case (state)
                HUNT: begin
                    if (fill_ok && com_hit) begin
                        bit_cnt <= '0;
                        com_cnt <= CW'(1);
                        if (COM_COUNT == 1) begin
                            state  <= ACTIVE;
                            active <= 1'b1;
                        end else begin
                            state <= LOCKING;
                        end
                    end
                end
                LOCKING: begin
                    if (boundary) begin
                        if (com_hit) begin
                            com_cnt <= com_cnt + 1'b1;
                            if (com_cnt == CW'(COM_COUNT - 1)) begin
                                state  <= ACTIVE;
                                active <= 1'b1;
                            end
                        end else begin
                            state   <= HUNT;
                            com_cnt <= '0;
                        end
                    end
                end
                ACTIVE: begin
                    if (boundary) begin
                        if (!com_hit) begin
                            data_out  <= window;
                            valid_out <= 1'b1;
`ifdef SP_LOSS_DETECT_EN
                            if (gap_expire) begin
                                gap_cnt <= '0;
                                state   <= HUNT;
                                active  <= 1'b0;
                                com_cnt <= '0;
                            end else begin
                                gap_cnt <= gap_cnt + 1'b1;
                            end
                        end else begin
                            gap_cnt <= '0;
`endif
                        end
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule
